// File: rtl/gshare_predictor_param.sv
// gshare_predictor_param
// Gshare branch direction predictor: a PHT of saturating counters indexed by
// addr XOR global history, with an in-order queue of outstanding predictions
// that are trained (and history updated) as branches resolve.
// Optional build macro: GSHARE_STATS_EN adds lookup_cnt / mispredict_cnt
// statistics outputs; without it those ports and counters do not exist.
module gshare_predictor_param #(
  parameter int ADDR_W = 11,
  parameter int GHR_W  = 4,
  parameter int CNT_W  = 2,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch,
  input  logic [ADDR_W-1:0] addr,
  output logic              branch_ready,
  output logic              prediction,
  output logic              pred_valid,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              resolve_err
`ifdef GSHARE_STATS_EN
  ,
  output logic [15:0]       lookup_cnt,
  output logic [15:0]       mispredict_cnt
`endif
);

  localparam int PHT_D = 1 << GHR_W;
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QC_W  = PTR_W + 1;

  localparam int CNT_INIT_I = (1 << (CNT_W - 1)) - 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_I);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [QC_W-1:0]  Q_FULL   = QC_W'(QDEPTH);
  localparam logic [QC_W-1:0]  QC_ONE   = QC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Pattern history table and non-speculative global history
  logic [CNT_W-1:0] pht [PHT_D];
  logic [GHR_W-1:0] ghr;

  // Outstanding-branch queue: PHT index and the predicted bit per entry
  logic [GHR_W-1:0] fifo_idx  [QDEPTH];
  logic             fifo_pred [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [QC_W-1:0]  count;

  logic             lookup_acc;
  logic             resolve_acc;
  logic             resolve_empty;
  logic [GHR_W-1:0] lookup_idx;
  logic             lookup_pred;
  logic [GHR_W-1:0] res_idx;
  logic             res_pred;
  logic [CNT_W-1:0] res_cnt;
  logic [CNT_W-1:0] res_cnt_next;

  // Only the low GHR_W address bits take part in indexing
  logic unused_addr;
  assign unused_addr = ^addr;

  // Full check uses the registered count, so a same-cycle pop never frees a slot early
  assign branch_ready  = (count < Q_FULL);
  assign lookup_acc    = branch & branch_ready;
  assign resolve_acc   = resolve_valid & (count != '0);
  assign resolve_empty = resolve_valid & (count == '0);

  assign lookup_idx  = addr[GHR_W-1:0] ^ ghr;
  assign lookup_pred = pht[lookup_idx][CNT_W-1];
  assign res_idx     = fifo_idx[rd_ptr];
  assign res_pred    = fifo_pred[rd_ptr];
  assign res_cnt     = pht[res_idx];

  // Saturating up/down step for the counter being trained
  always_comb begin
    res_cnt_next = res_cnt;
    if (resolve_taken) begin
      if (res_cnt != CNT_MAX) res_cnt_next = res_cnt + CNT_ONE;
    end else begin
      if (res_cnt != '0) res_cnt_next = res_cnt - CNT_ONE;
    end
  end

  // PHT training on resolve; reset returns every entry to weakly not-taken
  always_ff @(posedge clk) begin
    if (reset) begin
      pht <= '{default: CNT_INIT};
    end else if (resolve_acc) begin
      pht[res_idx] <= res_cnt_next;
    end
  end

  // Global history shifts in the actual outcome of each resolved branch
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (resolve_acc) begin
      // Truncating cast drops the old MSB and stays legal for GHR_W == 1
      ghr <= GHR_W'({ghr, resolve_taken});
    end
  end

  // Queue payload; pointers alone define validity so the data needs no reset
  always_ff @(posedge clk) begin
    if (!reset && lookup_acc) begin
      fifo_idx[wr_ptr]  <= lookup_idx;
      fifo_pred[wr_ptr] <= lookup_pred;
    end
  end

  // Queue pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (lookup_acc)  wr_ptr <= wr_ptr + PTR_ONE;
      if (resolve_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({lookup_acc, resolve_acc})
        2'b10:   count <= count + QC_ONE;
        2'b01:   count <= count - QC_ONE;
        default: count <= count;
      endcase
    end
  end

  // Registered prediction, its qualifier and the empty-resolve error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      prediction  <= 1'b0;
      pred_valid  <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      pred_valid  <= lookup_acc;
      resolve_err <= resolve_empty;
      if (lookup_acc) prediction <= lookup_pred;
    end
  end

`ifdef GSHARE_STATS_EN
  // Saturating statistics: accepted lookups and resolves that contradict the stored prediction
  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (lookup_acc && lookup_cnt != 16'hFFFF)
        lookup_cnt <= lookup_cnt + 16'd1;
      if (resolve_acc && (res_pred != resolve_taken) && mispredict_cnt != 16'hFFFF)
        mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end
`else
  logic unused_pred;
  assign unused_pred = res_pred;
`endif

endmodule

// File: tb/tb_gshare_predictor_param.sv
// tb_gshare_predictor_param
// Directed scoreboard bench for gshare_predictor_param at default parameters.
// Stimulus tasks queue the expected prediction / resolve_err pulses; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
// Statistics checks are included when GSHARE_STATS_EN is defined.
module tb_gshare_predictor_param;

  localparam int ADDR_W = 11;
  localparam int GHR_W  = 4;
  localparam int CNT_W  = 2;
  localparam int QDEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              branch;
  logic [ADDR_W-1:0] addr;
  logic              branch_ready;
  logic              prediction;
  logic              pred_valid;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              resolve_err;
`ifdef GSHARE_STATS_EN
  logic [15:0]       lookup_cnt;
  logic [15:0]       mispredict_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          exp_pred_q[$];
  bit          exp_err_q[$];

  gshare_predictor_param #(
    .ADDR_W(ADDR_W),
    .GHR_W (GHR_W),
    .CNT_W (CNT_W),
    .QDEPTH(QDEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .branch       (branch),
    .addr         (addr),
    .branch_ready (branch_ready),
    .prediction   (prediction),
    .pred_valid   (pred_valid),
    .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken),
    .resolve_err  (resolve_err)
`ifdef GSHARE_STATS_EN
    ,
    .lookup_cnt    (lookup_cnt),
    .mispredict_cnt(mispredict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (pred_valid !== 1'b0) begin
      if (exp_pred_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pred_valid: got %b expected 0 (t=%0t)", pred_valid, $time);
      end else begin
        automatic bit e = exp_pred_q.pop_front();
        check("prediction", {31'd0, prediction}, {31'd0, e});
      end
    end
    if (resolve_err !== 1'b0) begin
      if (exp_err_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resolve_err: got %b expected 0 (t=%0t)", resolve_err, $time);
      end else begin
        void'(exp_err_q.pop_front());
        check("resolve_err", {31'd0, resolve_err}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch        = 1'b0;
    addr          = '0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
  endtask

  task automatic lookup(input logic [ADDR_W-1:0] a, input bit exp);
    branch = 1'b1;
    addr   = a;
    exp_pred_q.push_back(exp);
    tick();
    idle();
  endtask

  task automatic lookup_ignored(input logic [ADDR_W-1:0] a);
    branch = 1'b1;
    addr   = a;
    tick();
    idle();
  endtask

  task automatic resolve(input bit t);
    resolve_valid = 1'b1;
    resolve_taken = t;
    tick();
    idle();
  endtask

  task automatic resolve_on_empty(input bit t);
    resolve_valid = 1'b1;
    resolve_taken = t;
    exp_err_q.push_back(1'b1);
    tick();
    idle();
  endtask

  task automatic lookup_and_resolve(input logic [ADDR_W-1:0] a, input bit acc, input bit exp,
                                    input bit t);
    branch        = 1'b1;
    addr          = a;
    resolve_valid = 1'b1;
    resolve_taken = t;
    if (acc) exp_pred_q.push_back(exp);
    tick();
    idle();
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $finish;
  end

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_prediction", {31'd0, prediction}, 32'd0);
    check("reset_pred_valid", {31'd0, pred_valid}, 32'd0);
    check("reset_resolve_err", {31'd0, resolve_err}, 32'd0);
    check("reset_branch_ready", {31'd0, branch_ready}, 32'd1);

    // First lookup: PHT weakly not-taken
    lookup(11'd0, 1'b0);
    // Train index 0 towards taken through changing history
    resolve(1'b1);            // PHT0=2 ghr=1
    lookup(11'd1, 1'b1);
    resolve(1'b1);            // PHT0=3 ghr=3
    lookup(11'd3, 1'b1);
    resolve(1'b1);            // PHT0=3 (sat) ghr=7
    lookup(11'd7, 1'b1);
    resolve(1'b0);            // PHT0=2 ghr=E
    lookup(11'd14, 1'b1);
    resolve(1'b0);            // PHT0=1 ghr=C
    lookup(11'd12, 1'b0);
    resolve(1'b1);            // PHT0=2 ghr=9

    // Resolve on empty queue: error pulse, no history/PHT change
    resolve_on_empty(1'b1);
    lookup(11'd9, 1'b1);      // idx 0 only if ghr still 9
    resolve(1'b0);            // PHT0=1 ghr=2

    // Fill the queue
    lookup(11'd0, 1'b0);      // idx 2
    lookup(11'd1, 1'b0);      // idx 3
    lookup(11'd2, 1'b0);      // idx 0
    lookup(11'd3, 1'b0);      // idx 1
    check("full_branch_ready", {31'd0, branch_ready}, 32'd0);
    lookup_ignored(11'd5);
    check("full_after_ignored", {31'd0, branch_ready}, 32'd0);
    // Full: lookup ignored, resolve pops idx2 (PHT2=2, ghr=5)
    lookup_and_resolve(11'd6, 1'b0, 1'b0, 1'b1);
    check("ready_after_pop", {31'd0, branch_ready}, 32'd1);
    // Count 3: lookup uses pre-update ghr=5/PHT3=1, resolve pops idx3 (ghr=B)
    lookup_and_resolve(11'd6, 1'b1, 1'b0, 1'b1);
    check("ready_count3", {31'd0, branch_ready}, 32'd1);
    lookup(11'd0, 1'b0);      // idx B, count 4
    check("count_held_full", {31'd0, branch_ready}, 32'd0);
    resolve(1'b1);            // 3 outstanding

    // Reset mid-stream with live inputs that must be ignored
    reset         = 1'b1;
    branch        = 1'b1;
    addr          = '0;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle();
    check("midreset_branch_ready", {31'd0, branch_ready}, 32'd1);
    check("midreset_pred_valid", {31'd0, pred_valid}, 32'd0);
    resolve_on_empty(1'b1);   // queue was discarded
    lookup(11'd0, 1'b0);      // PHT and ghr back to reset values
    resolve(1'b0);            // correct, PHT0=0
    lookup(11'd1, 1'b0);
    lookup(11'd2, 1'b0);
    lookup(11'd3, 1'b0);
    lookup(11'd4, 1'b0);
    resolve(1'b1);            // wrong
    resolve(1'b1);            // wrong
    resolve(1'b0);
    resolve(1'b0);
    check("drained_branch_ready", {31'd0, branch_ready}, 32'd1);
    tick();
    tick();
`ifdef GSHARE_STATS_EN
    check("lookup_cnt", {16'd0, lookup_cnt}, 32'd5);
    check("mispredict_cnt", {16'd0, mispredict_cnt}, 32'd2);
`endif
    check("pred_queue_drained", exp_pred_q.size(), 32'd0);
    check("err_queue_drained", exp_err_q.size(), 32'd0);
    summary();
    $finish;
  end

endmodule
